// File: rtl/zmips_alu_seq.sv
// Multi-cycle zMIPS ALU: ADD/SUB/logic in 1 cycle, shifts in shamt cycles, MUL in WIDTH cycles.
// Valid/ready on both sides; result registers hold steady in DONE until out_ready.
module zmips_alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             cout,
  output logic             err
);

  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_SLL = 4'h2;
  localparam logic [3:0] OP_SRL = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_MUL = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h8;
  localparam logic [3:0] OP_EOR = 4'hC;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] mpl_q, mpl_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

  logic             idle;
  logic             busy_last;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_mpl;
  logic [WIDTH-1:0] src_acc;
  logic [3:0]       src_op;
  logic [CW-1:0]    shamt;
  logic             op_is_shift;
  logic [WIDTH-1:0] shift_val;
  logic             shift_out;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_mpl;
  logic [WIDTH:0]   addsub;

  assign idle      = (state_q == IDLE);
  assign busy_last = (state_q == BUSY) && (cnt_q == CW'(1));

  // The accept cycle performs the first iteration straight from the ports,
  // so an N-step op finishes N edges after it was accepted.
  assign src_a   = idle ? a : a_q;
  assign src_mpl = idle ? b : mpl_q;
  assign src_acc = idle ? '0 : acc_q;
  assign src_op  = idle ? op : op_q;

  assign shamt       = {1'b0, b[SHW-1:0]};
  assign op_is_shift = (op == OP_SLL) || (op == OP_SRL);

  assign shift_val = src_op[0] ? {1'b0, src_a[WIDTH-1:1]} : {src_a[WIDTH-2:0], 1'b0};
  assign shift_out = src_op[0] ? src_a[0] : src_a[WIDTH-1];

  // Shift-add step: {acc, mpl} shifts right as the multiplier bits are consumed.
  assign mul_sum = {1'b0, src_acc} + (src_mpl[0] ? {1'b0, src_a} : '0);
  assign mul_acc = mul_sum[WIDTH:1];
  assign mul_mpl = {mul_sum[0], src_mpl[WIDTH-1:1]};

  assign addsub = {1'b0, a} + {1'b0, b ^ {WIDTH{op[0]}}} + {{WIDTH{1'b0}}, op[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      mpl_q   <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      zero_q  <= 1'b1;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mpl_q   <= mpl_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            state_d = BUSY;
          end else if (op_is_shift && (shamt > CW'(1))) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    mpl_d  = mpl_q;
    acc_d  = acc_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    y_d    = y_q;
    cout_d = cout_q;
    err_d  = err_q;

    if (idle && in_valid) begin
      op_d  = op;
      a_d   = a;
      mpl_d = b;
      acc_d = '0;
      cnt_d = '0;
      case (op)
        OP_ADD, OP_SUB: begin
          y_d    = addsub[WIDTH-1:0];
          cout_d = addsub[WIDTH];
          err_d  = 1'b0;
        end
        OP_AND, OP_OR, OP_EOR: begin
          y_d    = (op == OP_AND) ? (a & b) : (op == OP_OR) ? (a | b) : (a ^ b);
          cout_d = 1'b0;
          err_d  = 1'b0;
        end
        OP_SLL, OP_SRL: begin
          if (shamt == '0) begin
            y_d    = a;
            cout_d = 1'b0;
            err_d  = 1'b0;
          end else if (shamt == CW'(1)) begin
            y_d    = shift_val;
            cout_d = shift_out;
            err_d  = 1'b0;
          end else begin
            a_d   = shift_val;
            cnt_d = shamt - CW'(1);
          end
        end
        OP_MUL: begin
          mpl_d = mul_mpl;
          acc_d = mul_acc;
          cnt_d = CW'(WIDTH - 1);
        end
        default: begin
          y_d    = '0;
          cout_d = 1'b0;
          err_d  = 1'b1;
        end
      endcase
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - CW'(1);
      if (op_q == OP_MUL) begin
        mpl_d = mul_mpl;
        acc_d = mul_acc;
        if (busy_last) begin
          y_d    = mul_mpl;
          cout_d = |mul_acc;
          err_d  = 1'b0;
        end
      end else begin
        a_d = shift_val;
        if (busy_last) begin
          y_d    = shift_val;
          cout_d = shift_out;
          err_d  = 1'b0;
        end
      end
    end

    zero_d = ~|y_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_zmips_alu_seq.sv
// Directed bench for zmips_alu_seq: a 32-bit instance and an 8-bit instance.
module tb_zmips_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, zero, cout, err;
  logic [31:0] a, b, y;
  logic [3:0]  op;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, zero8, cout8, err8;
  logic [7:0]  a8, b8, y8;
  logic [3:0]  op8;

  int n_pass = 0;
  int n_chk  = 0;
  int lat;
  int seen;

  always #5 clk = ~clk;

  zmips_alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .cout(cout), .err(err)
  );

  zmips_alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .y(y8), .zero(zero8), .cout(cout8), .err(err8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called #1 after a rising edge with the DUT idle; returns with the result presented.
  task automatic run32(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                       input bit toggle, output int l);
    op = o; a = va; b = vb; in_valid = 1'b1;
    @(posedge clk); #1;
    l = 1;
    if (!toggle) in_valid = 1'b0;
    while (!out_valid && l < 200) begin
      if (toggle) begin
        a  = $urandom;
        b  = $urandom;
        op = 4'($urandom);
      end
      @(posedge clk); #1;
      l = l + 1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run8(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                      output int l);
    op8 = o; a8 = va; b8 = vb; in_valid8 = 1'b1;
    @(posedge clk); #1;
    l = 1;
    in_valid8 = 1'b0;
    while (!out_valid8 && l < 200) begin
      @(posedge clk); #1;
      l = l + 1;
    end
  endtask

  task automatic take32();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic take8();
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic res32(input string tag, input int l, input int exp_l, input logic [31:0] ey,
                       input logic ec, input logic ee);
    chk({tag, ".lat"}, 64'(l), 64'(exp_l));
    chk({tag, ".y"}, 64'(y), 64'(ey));
    chk({tag, ".zero"}, 64'(zero), 64'(ey == 32'h0));
    chk({tag, ".cout"}, 64'(cout), 64'(ec));
    chk({tag, ".err"}, 64'(err), 64'(ee));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'(1));
    chk("rst.out_valid", 64'(out_valid), 64'(0));
    chk("rst.y", 64'(y), 64'(0));
    chk("rst.zero", 64'(zero), 64'(1));
    chk("rst.cout", 64'(cout), 64'(0));
    chk("rst.err", 64'(err), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run32(4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    res32("add_wrap", lat, 1, 32'h0, 1'b1, 1'b0);
    take32();

    run32(4'h1, 32'd5, 32'd7, 1'b0, lat);
    res32("sub_5_7", lat, 1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    take32();

    run32(4'h1, 32'd7, 32'd5, 1'b0, lat);
    res32("sub_7_5", lat, 1, 32'd2, 1'b1, 1'b0);
    take32();
    chk("retain.out_valid", 64'(out_valid), 64'(0));
    chk("retain.y", 64'(y), 64'(2));

    run32(4'h4, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, lat);
    res32("and", lat, 1, 32'hF000_F000, 1'b0, 1'b0);
    // Hold the result under backpressure while a new op is offered.
    op = 4'h0; a = 32'h1; b = 32'h1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.y", 64'(y), 64'hF000_F000);
      chk("bp.in_ready", 64'(in_ready), 64'(0));
      chk("bp.out_valid", 64'(out_valid), 64'(1));
    end
    in_valid = 1'b0;
    take32();

    run32(4'h8, 32'h0000_0F00, 32'h0000_00F0, 1'b0, lat);
    res32("or", lat, 1, 32'h0000_0FF0, 1'b0, 1'b0);
    take32();

    run32(4'hC, 32'h1234_5678, 32'h1234_5678, 1'b0, lat);
    res32("eor_eq", lat, 1, 32'h0, 1'b0, 1'b0);
    take32();

    run32(4'h2, 32'h8000_0001, 32'd1, 1'b0, lat);
    res32("sll1", lat, 1, 32'h0000_0002, 1'b1, 1'b0);
    take32();

    run32(4'h3, 32'h0000_0100, 32'd8, 1'b0, lat);
    res32("srl8", lat, 8, 32'h0000_0001, 1'b0, 1'b0);
    take32();

    run32(4'h2, 32'hDEAD_BEEF, 32'h0000_0020, 1'b0, lat);
    res32("sll0", lat, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    take32();

    run32(4'h7, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, lat);
    res32("illegal", lat, 1, 32'h0, 1'b0, 1'b1);
    take32();

    run32(4'h6, 32'h0001_0000, 32'h0001_0000, 1'b0, lat);
    res32("mul_ovf", lat, 32, 32'h0, 1'b1, 1'b0);
    take32();

    run32(4'h6, 32'd123, 32'd456, 1'b1, lat);
    res32("mul_toggle", lat, 32, 32'd56088, 1'b0, 1'b0);
    take32();

    run8(4'h6, 8'd16, 8'd16, lat);
    chk("w8_mul.lat", 64'(lat), 64'(8));
    chk("w8_mul.y", 64'(y8), 64'(0));
    chk("w8_mul.zero", 64'(zero8), 64'(1));
    chk("w8_mul.cout", 64'(cout8), 64'(1));
    take8();

    run8(4'h3, 8'h80, 8'd7, lat);
    chk("w8_srl.lat", 64'(lat), 64'(7));
    chk("w8_srl.y", 64'(y8), 64'(1));
    chk("w8_srl.cout", 64'(cout8), 64'(0));
    take8();

    // Abort a multiply mid-flight with reset.
    op = 4'h6; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort.busy_in_ready", 64'(in_ready), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("abort.in_ready", 64'(in_ready), 64'(1));
    chk("abort.out_valid", 64'(out_valid), 64'(0));
    chk("abort.y", 64'(y), 64'(0));
    chk("abort.zero", 64'(zero), 64'(1));
    chk("abort.cout", 64'(cout), 64'(0));
    chk("abort.err", 64'(err), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = seen + 1;
    end
    chk("abort.no_out_valid", 64'(seen), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/zmips_alu_seq.md
Name: zmips_alu_seq

Overview:
- Parametrised, multi-cycle successor to the zMIPS combinational ALU.
- Keeps the ADD/SUB/AND/OR/EOR op encoding and adds iterative shifts and an iterative multiply.
- Operands and results move over valid/ready handshakes, so the core can stall on long ops.
- Sits between the register-read stage and writeback.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  ALU can accept an op this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for shifts, b[SHW-1:0] is the shift amount.
- op  in  4  operation code.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result this cycle.
- y  out  WIDTH  registered result.
- zero  out  1  registered; equals ~|y.
- cout  out  1  registered carry/flag, defined per op below.
- err  out  1  registered; 1 when the accepted op code was illegal.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, y=0, zero=1, cout=0, err=0. Internal counters and accumulators are cleared.
- Reset asserted mid-operation aborts the op immediately; no result is produced.
- FSM states: IDLE, BUSY, DONE.
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
- Accept: in_valid & in_ready at a rising edge latches a, b and op.
- Single-cycle ops go IDLE→DONE; out_valid rises 1 cycle after accept.
- Op codes (op[0]=1 selects subtract within ADD/SUB):
  - 0x0 ADD: y = a+b; cout = carry out of bit WIDTH-1.
  - 0x1 SUB: y = a + ~b + 1; cout = carry out (1 means no borrow, i.e. a ≥ b unsigned).
  - 0x4 AND, 0x8 OR, 0xC EOR: bitwise; cout=0.
  - 0x2 SLL, 0x3 SRL (logical): shamt = b[SHW-1:0].
    - shamt=0: IDLE→DONE, y=a, cout=0.
    - Otherwise IDLE→BUSY. The value shifts one bit per cycle. out_valid rises exactly shamt cycles after accept.
    - cout = last bit shifted out.
  - 0x6 MUL (unsigned, shift-add): IDLE→BUSY for WIDTH cycles; out_valid rises exactly WIDTH cycles after accept.
    - y = low WIDTH bits of a*b.
    - cout = 1 iff the high WIDTH bits of the full product are nonzero.
  - Any other code: IDLE→DONE, y=0, zero=1, cout=0, err=1.
  - err=0 for all legal ops.
- BUSY: uses an internal down-counter of SHW+1 bits. The last BUSY cycle loads y/zero/cout/err and moves to DONE.
- DONE: y/zero/cout/err are held stable while out_valid=1 and out_ready=0 (backpressure). out_valid & out_ready at a rising edge moves to IDLE.
- No accept in the same cycle as a DONE→IDLE hand-off, because in_ready=0 in DONE. Peak throughput is one single-cycle op per 2 cycles.
- Outputs change only on entry to DONE. After hand-off they retain their last values in IDLE/BUSY, with out_valid=0.
- in_valid and operand changes while not in IDLE are ignored. a/b/op changing during BUSY must not affect the result.
- All arithmetic is modulo 2^WIDTH. zero is always computed from the registered y.

Test Plan:
- Reset: drive rst_n=0 mid-MUL (BUSY) → next sample shows in_ready=1, out_valid=0, y=0, zero=1, cout=0, err=0, with no spurious out_valid afterwards.
- ADD/SUB, WIDTH=32:
  - ADD 0xFFFFFFFF+0x1 → y=0, zero=1, cout=1; out_valid 1 cycle after accept.
  - SUB 5-7 → y=0xFFFFFFFE, cout=0.
  - SUB 7-5 → y=2, cout=1.
- Logic ops, with backpressure:
  - AND 0xF0F0F0F0,0xFF00FF00 → 0xF000F000.
  - EOR of equal operands → y=0, zero=1.
  - Hold out_ready=0 for 5 cycles → y stable, in_ready=0.
- Shifts:
  - SLL 0x80000001 by 1 → y=0x00000002, cout=1; out_valid 1 cycle after accept.
  - SRL 0x100 by 8 → y=1, cout=0; out_valid exactly 8 cycles after accept.
  - Shift by 0 → y=a, 1-cycle latency.
- MUL:
  - 0x10000*0x10000 → y=0, zero=1, cout=1; out_valid exactly 32 cycles after accept.
  - 123*456 → y=56088, cout=0.
  - Toggle a/b during BUSY → result unchanged.
- Illegal and width: op=0x7 → err=1, y=0, zero=1.
  - WIDTH=8 instance: MUL 16*16 → y=0, cout=1 after 8 cycles.
  - WIDTH=8 instance: SRL 0x80 by 7 → y=1.
